rf_wr_arbiter: RTL and testbench
================================

// Module: rf_wr_arbiter
//
// PURPOSE
//   Shares the single register-file write port (built from 16-bit enable-gated
//   register cells) between two writeback requesters: req0 = ALU/pipeline
//   writeback, req1 = multi-cycle unit (load/mul). Arbitration is round-robin
//   with a valid/ready handshake. The winner's address/data are registered and
//   driven as a one-hot write enable to the register file. Sits between the
//   WB stage and the register file.
//
// PARAMETERS
//   DATA_W  16  width of write data
//   ADDR_W  3   register index width (2**ADDR_W registers)
//
// PORTS
//   clk         in   1       clock, rising edge
//   rst         in   1       asynchronous reset, active-low (rst==0 resets)
//   hold        in   1       pipeline freeze; no grant while high
//   req0_valid  in   1       requester 0 has a write pending
//   req0_addr   in   ADDR_W  requester 0 destination register
//   req0_data   in   DATA_W  requester 0 write data
//   req0_ready  out  1       requester 0 accepted this cycle
//   req1_valid  in   1       requester 1 has a write pending
//   req1_addr   in   ADDR_W  requester 1 destination register
//   req1_data   in   DATA_W  requester 1 write data
//   req1_ready  out  1       requester 1 accepted this cycle
//   wr_en       out  2**ADDR_W  one-hot per-register write enable (0 = no write)
//   wr_data     out  DATA_W  data to the register file (shared by all cells)
//   wr_src      out  1       source of the current write (0 = req0, 1 = req1)
//   conflict    out  1       pulse: both requesters valid, same addr, same cycle
//
// BEHAVIOUR
//   - Handshake: a transfer occurs on a rising edge where reqN_valid && reqN_ready.
//     reqN_ready is combinational from both valids, hold, and last_grant.
//     Requesters hold valid/addr/data stable until ready; valid never depends
//     on ready.
//   - Grant rule (hold==0): only one valid -> grant it. Both valid -> grant
//     ~last_grant. None -> no grant. hold==1 -> both readies 0, last_grant kept.
//     Never both readies high.
//   - last_grant (1 bit) updates to the granted index on every transfer.
//     Reset value is 1, so req0 wins the first tie.
//   - Latency: 1 cycle. A transfer at edge k drives wr_en/wr_data/wr_src for
//     the cycle after edge k. The register file captures on edge k+1.
//     wr_en is zero in any cycle following an edge with no transfer.
//     wr_data/wr_src hold their last value when no transfer occurs.
//   - Back-to-back: a new transfer is allowed every cycle. Continuous dual
//     requests alternate 0,1,0,1...
//   - conflict: registered, with the same timing as wr_en. Set when both are
//     valid with equal addr and a grant occurs. Informational only; the loser
//     still writes on its later grant, so the last writer wins.
//   - Reset (async, any time, incl. mid-transfer): wr_en=0, wr_data=0,
//     wr_src=0, conflict=0, last_grant=1. While rst==0, readies are 0.
//     A transfer in flight is dropped; requesters must re-present.
//   - Deassertion of rst takes effect at the next rising edge (no glitch grant
//     while rst==0).
//
// TESTING
//   1. Reset: drive rst=0 with both valids high -> readies 0, wr_en=0,
//      wr_data=0. Release -> req0 granted first.
//   2. Single requester: req0 addr=3, data=16'hBEEF for 1 cycle ->
//      next cycle wr_en=8'b0000_1000, wr_data=16'hBEEF, wr_src=0.
//   3. Fairness: both valid for 6 cycles, addrs 1/2 -> grants alternate
//      0,1,0,1,0,1. wr_en alternates 8'h02/8'h04.
//   4. Hold: both valid, hold=1 for 3 cycles -> no readies, wr_en=0.
//      hold=0 -> grant resumes at ~last_grant.
//   5. Same-address conflict: both addr=5, data0=16'h1111, data1=16'h2222 ->
//      conflict pulses once. Writes 1111 then 2222 on consecutive cycles.
//   6. Mid-op reset: transfer accepted, rst=0 before the next edge -> wr_en
//      clears immediately and last_grant returns to 1.

Source files
------------

// File: rtl/rf_wr_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the WB
// pipeline (req0) and the multi-cycle unit (req1); the winner is registered one cycle.
module rf_wr_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    hold,
  input  logic                    req0_valid,
  input  logic [ADDR_W-1:0]       req0_addr,
  input  logic [DATA_W-1:0]       req0_data,
  output logic                    req0_ready,
  input  logic                    req1_valid,
  input  logic [ADDR_W-1:0]       req1_addr,
  input  logic [DATA_W-1:0]       req1_data,
  output logic                    req1_ready,
  output logic [(2**ADDR_W)-1:0]  wr_en,
  output logic [DATA_W-1:0]       wr_data,
  output logic                    wr_src,
  output logic                    conflict
);

  localparam int NREG = 2**ADDR_W;

  logic              grant0;
  logic              grant1;
  logic              xfer;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  logic              last_grant_q, last_grant_d;
  logic [NREG-1:0]   wr_en_q,      wr_en_d;
  logic [DATA_W-1:0] wr_data_q,    wr_data_d;
  logic              wr_src_q,     wr_src_d;
  logic              conflict_q,   conflict_d;

  // Readies are forced low while reset is asserted so no grant can glitch out.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst && !hold) begin
      grant0 = req0_valid && (!req1_valid || last_grant_q);
      grant1 = req1_valid && (!req0_valid || !last_grant_q);
    end
    xfer     = grant0 || grant1;
    sel_addr = grant1 ? req1_addr : req0_addr;
    sel_data = grant1 ? req1_data : req0_data;
  end

  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_dec
      assign wr_en_d[gi] = xfer && (sel_addr == ADDR_W'(gi));
    end
  endgenerate

  always_comb begin
    last_grant_d = last_grant_q;
    wr_data_d    = wr_data_q;
    wr_src_d     = wr_src_q;
    conflict_d   = 1'b0;
    if (xfer) begin
      last_grant_d = grant1;
      wr_data_d    = sel_data;
      wr_src_d     = grant1;
      conflict_d   = req0_valid && req1_valid && (req0_addr == req1_addr);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= 1'b1;
      wr_en_q      <= '0;
      wr_data_q    <= '0;
      wr_src_q     <= 1'b0;
      conflict_q   <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      wr_en_q      <= wr_en_d;
      wr_data_q    <= wr_data_d;
      wr_src_q     <= wr_src_d;
      conflict_q   <= conflict_d;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign wr_en      = wr_en_q;
  assign wr_data    = wr_data_q;
  assign wr_src     = wr_src_q;
  assign conflict   = conflict_q;

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Bench for rf_wr_arbiter: a rule-level model checked every falling edge,
// plus directed vectors with hand-computed literal expectations.
module tb_rf_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        hold;
  logic        req0_valid, req1_valid;
  logic [2:0]  req0_addr,  req1_addr;
  logic [15:0] req0_data,  req1_data;
  logic        req0_ready, req1_ready;
  logic [7:0]  wr_en;
  logic [15:0] wr_data;
  logic        wr_src;
  logic        conflict;

  int tests = 0;
  int fails = 0;

  rf_wr_arbiter #(.DATA_W(16), .ADDR_W(3)) dut (
    .clk(clk), .rst(rst), .hold(hold),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .wr_en(wr_en), .wr_data(wr_data), .wr_src(wr_src), .conflict(conflict)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who wins is "the only valid one, else whoever did not win last".
  logic        m_last    = 1'b1;
  logic [7:0]  m_wr_en   = 8'h00;
  logic [15:0] m_wr_data = 16'h0000;
  logic        m_wr_src  = 1'b0;
  logic        m_conf    = 1'b0;

  function automatic logic [1:0] m_ready();
    if (rst !== 1'b1 || hold) return 2'b00;
    if (req0_valid && req1_valid) return m_last ? 2'b01 : 2'b10;
    return {req1_valid, req0_valid};
  endfunction

  always @(negedge rst) begin
    m_last = 1'b1; m_wr_en = 8'h00; m_wr_data = 16'h0000; m_wr_src = 1'b0; m_conf = 1'b0;
  end

  always @(posedge clk) begin
    logic [1:0] r;
    if (rst === 1'b1) begin
      r = m_ready();
      if (r == 2'b10) begin
        m_wr_en = 8'h01 << req1_addr; m_wr_data = req1_data; m_wr_src = 1'b1; m_last = 1'b1;
      end else if (r == 2'b01) begin
        m_wr_en = 8'h01 << req0_addr; m_wr_data = req0_data; m_wr_src = 1'b0; m_last = 1'b0;
      end else begin
        m_wr_en = 8'h00;
      end
      m_conf = (r != 2'b00) && req0_valid && req1_valid && (req0_addr == req1_addr);
    end
  end

  always @(negedge clk) begin
    logic [1:0] r;
    r = m_ready();
    chk("model_ready0", req0_ready, r[0]);
    chk("model_ready1", req1_ready, r[1]);
    chk("model_wr_en", wr_en, m_wr_en);
    chk("model_wr_data", wr_data, m_wr_data);
    chk("model_wr_src", wr_src, m_wr_src);
    chk("model_conflict", conflict, m_conf);
  end

  logic [15:0] rf_mirror [8];
  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) if (wr_en[i]) rf_mirror[i] <= wr_data;
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input logic [2:0] a0, input logic [15:0] d0,
                       input logic v1, input logic [2:0] a1, input logic [15:0] d1);
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected end");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; hold = 1'b0;
    drive(1, 3'd1, 16'hA001, 1, 3'd2, 16'hB002);
    #1 rst = 1'b0;

    // Reset with both valids asserted
    @(negedge clk); @(negedge clk); #1;
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    chk("rst_wr_en", wr_en, 8'h00);
    chk("rst_wr_data", wr_data, 16'h0000);
    cycle();
    rst = 1'b1;
    #1;
    chk("rel_ready0", req0_ready, 1);
    chk("rel_ready1", req1_ready, 0);

    // Fairness: alternate 0,1,0,1,0,1
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("fair_src", wr_src, i % 2);
      chk("fair_wr_en", wr_en, (i % 2) ? 8'h04 : 8'h02);
      chk("fair_data", wr_data, (i % 2) ? 16'hB002 : 16'hA001);
    end

    // Hold freezes grants; last winner was req1 so req0 resumes
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("hold_ready0", req0_ready, 0);
      chk("hold_ready1", req1_ready, 0);
      chk("hold_wr_en", wr_en, 8'h00);
    end
    hold = 1'b0;
    cycle();
    chk("resume_src", wr_src, 0);
    chk("resume_wr_en", wr_en, 8'h02);
    drive(0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
    cycle();
    chk("idle_wr_en", wr_en, 8'h00);
    chk("idle_hold_data", wr_data, 16'hA001);

    // Single requester
    drive(1, 3'd3, 16'hBEEF, 0, 3'd0, 16'h0);
    cycle();
    drive(0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
    chk("single_wr_en", wr_en, 8'h08);
    chk("single_data", wr_data, 16'hBEEF);
    chk("single_src", wr_src, 0);
    cycle();
    chk("single_after_en", wr_en, 8'h00);
    chk("single_after_data", wr_data, 16'hBEEF);

    // req1 alone so that req0 wins the following tie
    drive(0, 3'd0, 16'h0, 1, 3'd6, 16'h0606);
    cycle();
    chk("r1_wr_en", wr_en, 8'h40);
    chk("r1_src", wr_src, 1);

    // Same-address conflict
    drive(1, 3'd5, 16'h1111, 1, 3'd5, 16'h2222);
    cycle();
    chk("conf_pulse", conflict, 1);
    chk("conf_first_data", wr_data, 16'h1111);
    chk("conf_first_en", wr_en, 8'h20);
    req0_valid = 1'b0;
    cycle();
    chk("conf_clear", conflict, 0);
    chk("conf_second_data", wr_data, 16'h2222);
    chk("conf_second_src", wr_src, 1);
    drive(0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
    cycle();
    chk("conf_idle", conflict, 0);
    chk("last_writer_wins", rf_mirror[5], 16'h2222);

    // Mid-op reset: wr_en must clear without waiting for a clock
    drive(0, 3'd0, 16'h0, 1, 3'd7, 16'h7777);
    cycle();
    chk("mid_wr_en", wr_en, 8'h80);
    rst = 1'b0;
    #1;
    chk("mid_rst_wr_en", wr_en, 8'h00);
    chk("mid_rst_data", wr_data, 16'h0000);
    chk("mid_rst_ready1", req1_ready, 0);
    drive(1, 3'd1, 16'hC001, 1, 3'd2, 16'hD002);
    cycle();
    chk("rst_low_wr_en", wr_en, 8'h00);
    rst = 1'b1;
    #1;
    chk("post_rst_ready0", req0_ready, 1);
    cycle();
    chk("post_rst_src", wr_src, 0);
    chk("post_rst_wr_en", wr_en, 8'h02);
    drive(0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
    cycle();
    cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
